// File: rtl/dmem_arbiter.sv
// Data-BRAM arbiter: CPU has absolute priority; a posted IPU write FIFO and
// accelerator reads share the remaining cycles round-robin.
module dmem_arbiter #(
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_ren,
   input  logic              cpu_wren,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ipu_wr_valid,
   input  logic [ADDR_W-1:0] ipu_wr_addr,
   input  logic [DATA_W-1:0] ipu_wr_data,
   output logic              ipu_wr_ready,
   output logic              ipu_busy,
   input  logic              acc_rd_req,
   input  logic [ADDR_W-1:0] acc_rd_addr,
   output logic              acc_rd_gnt,
   output logic              acc_rd_valid,
   output logic [DATA_W-1:0] acc_rd_data,
   output logic              bram_en,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_wdata,
   input  logic [DATA_W-1:0] bram_rdata
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W:0] DEPTH_CNT = FIFO_DEPTH[PTR_W:0];

   typedef enum logic {RR_IPU = 1'b0, RR_ACC = 1'b1} rr_t;
   typedef enum logic [1:0] {RD_NONE, RD_CPU, RD_ACC} rd_owner_t;
   typedef enum logic [1:0] {OWN_IDLE, OWN_CPU, OWN_IPU, OWN_ACC} owner_t;

   logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;

   rr_t       rr;
   rd_owner_t rd_owner;
   owner_t    owner;

   logic cpu_act;
   logic fifo_ne;
   logic push;
   logic pop;

   assign cpu_act      = cpu_ren | cpu_wren;
   assign fifo_ne      = (count != '0);
   assign ipu_wr_ready = (count != DEPTH_CNT);
   assign ipu_busy     = fifo_ne;
   assign push         = ipu_wr_valid & ipu_wr_ready;
   assign pop          = (owner == OWN_IPU);

   assign cpu_rdata    = bram_rdata;
   assign acc_rd_data  = bram_rdata;
   assign acc_rd_valid = (rd_owner == RD_ACC);

   always_comb begin
      owner = OWN_IDLE;
      if (cpu_act)
         owner = OWN_CPU;
      else if (fifo_ne && acc_rd_req)
         owner = (rr == RR_IPU) ? OWN_IPU : OWN_ACC;
      else if (fifo_ne)
         owner = OWN_IPU;
      else if (acc_rd_req)
         owner = OWN_ACC;
   end

   always_comb begin
      bram_en    = 1'b0;
      bram_we    = 1'b0;
      bram_addr  = '0;
      bram_wdata = '0;
      acc_rd_gnt = 1'b0;
      case (owner)
         OWN_CPU: begin
            // a simultaneous load+store is executed as the store
            bram_en    = 1'b1;
            bram_we    = cpu_wren;
            bram_addr  = cpu_addr;
            bram_wdata = cpu_wdata;
         end
         OWN_IPU: begin
            bram_en    = 1'b1;
            bram_we    = 1'b1;
            bram_addr  = fifo_addr[rd_ptr];
            bram_wdata = fifo_data[rd_ptr];
         end
         OWN_ACC: begin
            bram_en    = 1'b1;
            bram_addr  = acc_rd_addr;
            acc_rd_gnt = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= ipu_wr_addr;
         fifo_data[wr_ptr] <= ipu_wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rr       <= RR_IPU;
         rd_owner <= RD_NONE;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase

         // pointer only moves on a secondary grant, never on CPU cycles
         if (owner == OWN_IPU)
            rr <= RR_ACC;
         else if (owner == OWN_ACC)
            rr <= RR_IPU;

         case (owner)
            OWN_CPU: rd_owner <= cpu_wren ? RD_NONE : RD_CPU;
            OWN_ACC: rd_owner <= RD_ACC;
            default: rd_owner <= RD_NONE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural BRAM and write/read
// scoreboards checked on the falling clock edge.
module tb_dmem_arbiter;

   localparam int AW = 11;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          cpu_ren, cpu_wren;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          ipu_wr_valid, ipu_wr_ready, ipu_busy;
   logic [AW-1:0] ipu_wr_addr;
   logic [DW-1:0] ipu_wr_data;
   logic          acc_rd_req, acc_rd_gnt, acc_rd_valid;
   logic [AW-1:0] acc_rd_addr;
   logic [DW-1:0] acc_rd_data;
   logic          bram_en, bram_we;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_wdata;
   logic [DW-1:0] bram_rdata = '0;

   int n_cmp = 0;
   int n_err = 0;

   logic [AW+DW-1:0] ipu_q[$];
   logic [DW-1:0]    acc_q[$];
   logic [AW+DW-1:0] exp_wr;
   logic [DW-1:0]    exp_rd;

   logic [DW-1:0] mem [2048];
   logic [2047:0] wr_mask = '0;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_ren(cpu_ren), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .ipu_wr_valid(ipu_wr_valid), .ipu_wr_addr(ipu_wr_addr),
      .ipu_wr_data(ipu_wr_data), .ipu_wr_ready(ipu_wr_ready), .ipu_busy(ipu_busy),
      .acc_rd_req(acc_rd_req), .acc_rd_addr(acc_rd_addr), .acc_rd_gnt(acc_rd_gnt),
      .acc_rd_valid(acc_rd_valid), .acc_rd_data(acc_rd_data),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      return 16'h5A00 ^ {5'b0, a};
   endfunction

   function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
      return wr_mask[a] ? mem[a] : init_val(a);
   endfunction

   // single-port BRAM, 1-cycle registered read
   always @(posedge clk) begin
      if (bram_en) begin
         if (bram_we) begin
            mem[bram_addr]     <= bram_wdata;
            wr_mask[bram_addr] <= 1'b1;
         end else begin
            bram_rdata <= mem_rd(bram_addr);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bram_en && bram_we) begin
         if (cpu_wren) begin
            check("cpu_wr_addr", 32'(bram_addr), 32'(cpu_addr));
            check("cpu_wr_data", 32'(bram_wdata), 32'(cpu_wdata));
         end else if (ipu_q.size() == 0) begin
            check("ipu_wr_spurious", 32'(bram_we), 32'd0);
         end else begin
            exp_wr = ipu_q.pop_front();
            check("ipu_wr_order", 32'({bram_addr, bram_wdata}), 32'(exp_wr));
         end
      end
      if (acc_rd_valid) begin
         if (acc_q.size() == 0) begin
            check("acc_valid_spurious", 32'(acc_rd_valid), 32'd0);
         end else begin
            exp_rd = acc_q.pop_front();
            check("acc_rd_data", 32'(acc_rd_data), 32'(exp_rd));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic ipu_push(input logic [AW-1:0] a, input logic [DW-1:0] d);
      ipu_wr_valid = 1'b1;
      ipu_wr_addr  = a;
      ipu_wr_data  = d;
      ipu_q.push_back({a, d});
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (ipu_busy && k < 20) begin
         tick();
         k++;
      end
      check(tag, 32'(ipu_busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] exp_ready;
      logic [5:0] exp_g;
      logic       g, prev_g;
      int         j;

      cpu_ren = 0; cpu_wren = 0; cpu_addr = '0; cpu_wdata = '0;
      ipu_wr_valid = 0; ipu_wr_addr = '0; ipu_wr_data = '0;
      acc_rd_req = 0; acc_rd_addr = '0;

      #1 rst_n = 1'b0;
      #2;
      check("rst_ready", 32'(ipu_wr_ready), 32'd1);
      check("rst_busy", 32'(ipu_busy), 32'd0);
      check("rst_acc_valid", 32'(acc_rd_valid), 32'd0);
      check("rst_bram_en", 32'(bram_en), 32'd0);
      tick(); tick();
      rst_n = 1'b1;

      // CPU store then load, accelerator requesting throughout
      cpu_wren = 1; cpu_addr = 11'h010; cpu_wdata = 16'h0123;
      acc_rd_req = 1; acc_rd_addr = 11'h300;
      smp();
      check("t1_we", 32'(bram_we), 32'd1);
      check("t1_gnt_wr", 32'(acc_rd_gnt), 32'd0);
      tick();
      cpu_wren = 0; cpu_ren = 1;
      smp();
      check("t1_rd_we", 32'(bram_we), 32'd0);
      check("t1_rd_addr", 32'(bram_addr), 32'h010);
      check("t1_gnt_rd", 32'(acc_rd_gnt), 32'd0);
      tick();
      cpu_ren = 0; acc_rd_req = 0;
      smp();
      check("t1_cpu_rdata", 32'(cpu_rdata), 32'h0123);
      check("t1_acc_valid", 32'(acc_rd_valid), 32'd0);
      tick();

      // IPU streaming 5 writes with everything else idle
      for (int k = 0; k < 7; k++) begin
         if (k < 5) ipu_push(11'(11'h100 + k), 16'(16'h1000 + k));
         else ipu_wr_valid = 0;
         smp();
         if (k < 5) check("t2_ready", 32'(ipu_wr_ready), 32'd1);
         if (k == 5) check("t2_busy_last", 32'(ipu_busy), 32'd1);
         if (k == 6) check("t2_busy_fall", 32'(ipu_busy), 32'd0);
         tick();
      end
      for (int k = 0; k < 5; k++)
         check("t2_mem", 32'(mem_rd(11'(11'h100 + k))), 32'(16'h1000 + k));

      // CPU busy 6 cycles while IPU pushes: FIFO fills, no pass-through
      exp_ready = 8'b1000_1111;
      j = 0;
      for (int c = 0; c < 9; c++) begin
         cpu_ren = (c < 6); cpu_addr = 11'h010;
         if (j < 5) begin
            ipu_wr_valid = 1; ipu_wr_addr = 11'(11'h120 + j); ipu_wr_data = 16'(16'h2000 + j);
         end else begin
            ipu_wr_valid = 0;
         end
         smp();
         if (c < 8) check("t3_ready", 32'(ipu_wr_ready), 32'(exp_ready[c]));
         if (c < 6) check("t3_cpu_only", 32'(bram_we), 32'd0);
         if (c == 1) check("t3_cpu_rdata", 32'(cpu_rdata), 32'h0123);
         if (j < 5 && exp_ready[c]) begin
            ipu_q.push_back({ipu_wr_addr, ipu_wr_data});
            j++;
         end
         tick();
      end
      wait_idle("t3_drain");
      check("t3_q_empty", 32'(ipu_q.size()), 32'd0);

      // lone accelerator read; leaves the rr pointer preferring the IPU
      acc_rd_req = 1; acc_rd_addr = 11'h010;
      smp();
      check("rr_gnt", 32'(acc_rd_gnt), 32'd1);
      acc_q.push_back(16'h0123);
      tick();
      acc_rd_req = 0;
      smp();
      check("rr_valid", 32'(acc_rd_valid), 32'd1);
      tick();

      // 3 queued IPU writes vs continuous accelerator requests
      for (int c = 0; c < 3; c++) begin
         cpu_ren = 1;
         ipu_push(11'(11'h140 + c), 16'(16'h3000 + c));
         smp();
         tick();
      end
      cpu_ren = 0; ipu_wr_valid = 0; acc_rd_req = 1; acc_rd_addr = 11'h050;
      exp_g = 6'b101010;
      prev_g = 0;
      for (int c = 0; c < 6; c++) begin
         g = exp_g[c];
         smp();
         check("t4_gnt", 32'(acc_rd_gnt), 32'(g));
         check("t4_valid", 32'(acc_rd_valid), 32'(prev_g));
         check("t4_we", 32'(bram_we), 32'(!g));
         if (g) acc_q.push_back(init_val(acc_rd_addr));
         tick();
         if (g) acc_rd_addr = acc_rd_addr + 1'b1;
         if (c == 5) acc_rd_req = 0;
         prev_g = g;
      end
      smp();
      check("t4_valid_last", 32'(acc_rd_valid), 32'd1);
      tick();
      wait_idle("t4_drain");

      // read of an address with a queued write returns the old value
      ipu_push(11'h160, 16'h4444);
      smp(); tick();
      ipu_wr_valid = 0;
      smp(); tick();
      wait_idle("t5_pre");
      cpu_ren = 1;
      ipu_push(11'h200, 16'hBEEF);
      smp(); tick();
      ipu_wr_valid = 0; acc_rd_req = 1; acc_rd_addr = 11'h200;
      smp();
      check("t5_gnt_cpu", 32'(acc_rd_gnt), 32'd0);
      tick();
      cpu_ren = 0;
      smp();
      check("t5_gnt_acc", 32'(acc_rd_gnt), 32'd1);
      acc_q.push_back(init_val(11'h200));
      tick();
      acc_rd_req = 0;
      smp();
      check("t5_old_data", 32'(acc_rd_data), 32'(init_val(11'h200)));
      tick();
      wait_idle("t5_drain");
      acc_rd_req = 1; acc_rd_addr = 11'h200;
      smp();
      check("t5_regnt", 32'(acc_rd_gnt), 32'd1);
      acc_q.push_back(16'hBEEF);
      tick();
      acc_rd_req = 0;
      smp();
      check("t5_new_data", 32'(acc_rd_data), 32'hBEEF);
      tick();

      // reset with 2 entries pending and an accelerator read in flight
      for (int c = 0; c < 3; c++) begin
         cpu_ren = 1;
         ipu_wr_valid = 1; ipu_wr_addr = 11'(11'h180 + c); ipu_wr_data = 16'(16'h6000 + c);
         if (c == 0) ipu_q.push_back({ipu_wr_addr, ipu_wr_data});
         smp();
         tick();
      end
      cpu_ren = 0; ipu_wr_valid = 0; acc_rd_req = 1; acc_rd_addr = 11'h060;
      smp();
      check("t6_gnt_ipu_first", 32'(acc_rd_gnt), 32'd0);
      tick();
      smp();
      check("t6_gnt_acc", 32'(acc_rd_gnt), 32'd1);
      check("t6_busy_pre", 32'(ipu_busy), 32'd1);
      tick();
      rst_n = 1'b0; acc_rd_req = 0;
      #1;
      check("t6_busy_rst", 32'(ipu_busy), 32'd0);
      check("t6_valid_rst", 32'(acc_rd_valid), 32'd0);
      check("t6_ready_rst", 32'(ipu_wr_ready), 32'd1);
      tick(); tick();
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         smp();
         tick();
      end
      check("t6_mem_181", 32'(mem_rd(11'h181)), 32'(init_val(11'h181)));
      check("t6_mem_182", 32'(mem_rd(11'h182)), 32'(init_val(11'h182)));
      check("end_ipu_q", 32'(ipu_q.size()), 32'd0);
      check("end_acc_q", 32'(acc_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
